// File: rtl/movement_controller_pkg.sv
// Shared types and constants for the character movement controller.
// Character indices, direction encodings and default playfield geometry.
package movement_controller_pkg;

  localparam int POS_W  = 10;
  localparam int CAND_W = 11;
  localparam int NCHAR  = 4;

  localparam logic [1:0] MAGE     = 2'd0;
  localparam logic [1:0] GUNMAN   = 2'd1;
  localparam logic [1:0] SWORDMAN = 2'd2;
  localparam logic [1:0] FISTMAN  = 2'd3;

  localparam int DEF_CHAR_W = 32;
  localparam int DEF_CHAR_H = 32;
  localparam int DEF_MAX_X  = 640;
  localparam int DEF_MAX_Y  = 480;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REJECT = 2'd2
  } state_e;

endpackage

// File: rtl/movement_controller_if.sv
// Bundle between the movement controller and its environment:
// step requests in, detector query out, committed positions out.
interface movement_controller_if;
  logic [3:0] move_req;
  logic [7:0] dir;
  logic       move_allowed;
  logic [9:0] test_x;
  logic [9:0] test_y;
  logic [1:0] character_to_move;
  logic [9:0] xmage;
  logic [9:0] ymage;
  logic [9:0] xgunman;
  logic [9:0] ygunman;
  logic [9:0] xswordman;
  logic [9:0] yswordman;
  logic [9:0] xfistman;
  logic [9:0] yfistman;
  logic [3:0] move_ack;
  logic [3:0] move_granted;
  logic       busy;

  modport master (
    input  move_req, dir, move_allowed,
    output test_x, test_y, character_to_move,
    output xmage, ymage, xgunman, ygunman,
    output xswordman, yswordman, xfistman, yfistman,
    output move_ack, move_granted, busy
  );

  modport slave (
    output move_req, dir, move_allowed,
    input  test_x, test_y, character_to_move,
    input  xmage, ymage, xgunman, ygunman,
    input  xswordman, yswordman, xfistman, yfistman,
    input  move_ack, move_granted, busy
  );
endinterface

// File: rtl/movement_controller_arb.sv
// Four-way round-robin arbiter; search starts after the last grant.
// Pure combinational, one-hot grant plus encoded index.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       valid_o
);

  logic [1:0] k;

  // Walk from lowest to highest priority so the nearest winner lands last.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = '0;
    for (int i = 4; i >= 1; i--) begin
      k = last_i + 2'(i);
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = k;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/movement_controller.sv
// Round-robin step initiator for the collision detector.
// Owns committed positions; queries the detector one step at a time.
module movement_controller
  import movement_controller_pkg::*;
#(
  parameter int CHARACTER_WIDTH = DEF_CHAR_W,
  parameter int CHARACTER_HEIGHT = DEF_CHAR_H,
  parameter int MAX_X = DEF_MAX_X,
  parameter int MAX_Y = DEF_MAX_Y,
  parameter int STEP = 1,
  parameter int INIT_XMAGE = 0,
  parameter int INIT_YMAGE = 0,
  parameter int INIT_XGUNMAN = 64,
  parameter int INIT_YGUNMAN = 0,
  parameter int INIT_XSWORDMAN = 128,
  parameter int INIT_YSWORDMAN = 0,
  parameter int INIT_XFISTMAN = 192,
  parameter int INIT_YFISTMAN = 0
) (
  input logic clk,
  input logic rst_n,
  movement_controller_if.master bus
);

  localparam logic [10:0] S  = 11'(STEP);
  localparam logic [10:0] CW = 11'(CHARACTER_WIDTH);
  localparam logic [10:0] CH = 11'(CHARACTER_HEIGHT);
  localparam logic [10:0] MX = 11'(MAX_X);
  localparam logic [10:0] MY = 11'(MAX_Y);

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [1:0] ctm_q;
  logic [3:0] win_q;
  logic [3:0] ack_q;
  logic [3:0] grant_q;
  logic       busy_q;
  logic [9:0] tx_q;
  logic [9:0] ty_q;
  logic [9:0] x_q [NCHAR];
  logic [9:0] y_q [NCHAR];

  logic [3:0] arb_gnt;
  logic [1:0] arb_idx;
  logic       arb_valid;

  rr_arbiter4 u_arb (
    .req_i   (bus.move_req),
    .last_i  (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  dir_e        d;
  logic [10:0] cur_x;
  logic [10:0] cur_y;
  logic [10:0] cx;
  logic [10:0] cy;
  logic        oob;

  // Candidate and bounds in 11 bits so edge sums never wrap.
  always_comb begin
    cur_x = {1'b0, x_q[arb_idx]};
    cur_y = {1'b0, y_q[arb_idx]};
    d     = dir_e'(bus.dir[{arb_idx, 1'b0} +: 2]);
    cx    = cur_x;
    cy    = cur_y;
    oob   = 1'b0;
    unique case (d)
      DIR_UP: begin
        oob = cur_y < S;
        cy  = cur_y - S;
      end
      DIR_DOWN: begin
        oob = (cur_y + S + CH) > MY;
        cy  = cur_y + S;
      end
      DIR_LEFT: begin
        oob = cur_x < S;
        cx  = cur_x - S;
      end
      DIR_RIGHT: begin
        oob = (cur_x + S + CW) > MX;
        cx  = cur_x + S;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd3;
      ctm_q   <= '0;
      win_q   <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      tx_q    <= '0;
      ty_q    <= '0;
      x_q[MAGE]     <= 10'(INIT_XMAGE);
      y_q[MAGE]     <= 10'(INIT_YMAGE);
      x_q[GUNMAN]   <= 10'(INIT_XGUNMAN);
      y_q[GUNMAN]   <= 10'(INIT_YGUNMAN);
      x_q[SWORDMAN] <= 10'(INIT_XSWORDMAN);
      y_q[SWORDMAN] <= 10'(INIT_YSWORDMAN);
      x_q[FISTMAN]  <= 10'(INIT_XFISTMAN);
      y_q[FISTMAN]  <= 10'(INIT_YFISTMAN);
    end else begin
      ack_q   <= '0;
      grant_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            ctm_q  <= arb_idx;
            win_q  <= arb_gnt;
            busy_q <= 1'b1;
            if (oob) begin
              state_q <= ST_REJECT;
            end else begin
              tx_q    <= cx[9:0];
              ty_q    <= cy[9:0];
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (bus.move_allowed) begin
            x_q[ctm_q] <= tx_q;
            y_q[ctm_q] <= ty_q;
            grant_q    <= win_q;
          end
          ack_q   <= win_q;
          ptr_q   <= ctm_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_REJECT: begin
          ack_q   <= win_q;
          ptr_q   <= ctm_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.test_x            = tx_q;
  assign bus.test_y            = ty_q;
  assign bus.character_to_move = ctm_q;
  assign bus.move_ack          = ack_q;
  assign bus.move_granted      = grant_q;
  assign bus.busy              = busy_q;
  assign bus.xmage             = x_q[MAGE];
  assign bus.ymage             = y_q[MAGE];
  assign bus.xgunman           = x_q[GUNMAN];
  assign bus.ygunman           = y_q[GUNMAN];
  assign bus.xswordman         = x_q[SWORDMAN];
  assign bus.yswordman         = y_q[SWORDMAN];
  assign bus.xfistman          = x_q[FISTMAN];
  assign bus.yfistman          = y_q[FISTMAN];

endmodule

// File: tb/tb_movement_controller.sv
// Directed bench for movement_controller with an ack scoreboard
// and a small reference model of positions and bounds.
module tb_movement_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  movement_controller_if bus ();

  movement_controller #(
    .INIT_XGUNMAN (33),
    .INIT_XFISTMAN(607)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] ack;
    logic [3:0] gnt;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  int mx[4];
  int my[4];
  int ltx;
  int lty;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = '{0, 33, 128, 607};
    my = '{0, 0, 0, 0};
    ltx = 0;
    lty = 0;
    sbq.delete();
  endtask

  task automatic check_pos(input string tag);
    check({tag, " xmage"}, 32'(bus.xmage), 32'(mx[0]));
    check({tag, " ymage"}, 32'(bus.ymage), 32'(my[0]));
    check({tag, " xgunman"}, 32'(bus.xgunman), 32'(mx[1]));
    check({tag, " ygunman"}, 32'(bus.ygunman), 32'(my[1]));
    check({tag, " xswordman"}, 32'(bus.xswordman), 32'(mx[2]));
    check({tag, " yswordman"}, 32'(bus.yswordman), 32'(my[2]));
    check({tag, " xfistman"}, 32'(bus.xfistman), 32'(mx[3]));
    check({tag, " yfistman"}, 32'(bus.yfistman), 32'(my[3]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.move_req = '0;
    bus.dir = '0;
    bus.move_allowed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic predict(input int w, input logic [1:0] d,
                         output bit oob, output int nx, output int ny);
    nx = mx[w];
    ny = my[w];
    oob = 1'b0;
    case (d)
      2'b00: if (my[w] < 1) oob = 1'b1; else ny = my[w] - 1;
      2'b01: if (my[w] + 1 + 32 > 480) oob = 1'b1; else ny = my[w] + 1;
      2'b10: if (mx[w] < 1) oob = 1'b1; else nx = mx[w] - 1;
      default: if (mx[w] + 1 + 32 > 640) oob = 1'b1; else nx = mx[w] + 1;
    endcase
  endtask

  task automatic step(input string tag, input int w,
                      input logic [1:0] d, input bit allowed);
    bit oob;
    int nx;
    int ny;
    exp_t e;
    predict(w, d, oob, nx, ny);
    e.ack = 4'(1 << w);
    e.gnt = (!oob && allowed) ? 4'(1 << w) : 4'b0;
    sbq.push_back(e);
    @(negedge clk);
    bus.move_req = 4'(1 << w);
    bus.dir = 8'(d) << (2 * w);
    bus.move_allowed = allowed;
    @(posedge clk);
    @(negedge clk);
    bus.move_req = '0;
    bus.dir = ~bus.dir;
    if (!oob) begin
      ltx = nx;
      lty = ny;
    end
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    check({tag, " test_x"}, 32'(bus.test_x), 32'(ltx));
    check({tag, " test_y"}, 32'(bus.test_y), 32'(lty));
    check({tag, " ctm"}, 32'(bus.character_to_move), 32'(w));
    check({tag, " early ack"}, 32'(bus.move_ack), 32'd0);
    @(posedge clk);
    @(negedge clk);
    e = sbq.pop_front();
    check({tag, " ack"}, 32'(bus.move_ack), 32'(e.ack));
    check({tag, " granted"}, 32'(bus.move_granted), 32'(e.gnt));
    if (!oob && allowed) begin
      mx[w] = nx;
      my[w] = ny;
    end
    check_pos(tag);
    check({tag, " idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    bus.move_req = '0;
    bus.dir = '0;
    bus.move_allowed = 1'b0;
    model_reset();
    do_reset();

    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst ack", 32'(bus.move_ack), 32'd0);
    check("rst granted", 32'(bus.move_granted), 32'd0);
    check("rst test_x", 32'(bus.test_x), 32'd0);
    check("rst test_y", 32'(bus.test_y), 32'd0);
    check("rst ctm", 32'(bus.character_to_move), 32'd0);
    check_pos("rst");

    step("mage up edge", 0, 2'b00, 1'b1);
    step("mage right", 0, 2'b11, 1'b1);
    step("gunman left deny", 1, 2'b10, 1'b0);
    step("fist right 607", 3, 2'b11, 1'b1);
    step("fist right 608", 3, 2'b11, 1'b1);
    step("sword down", 2, 2'b01, 1'b1);
    step("mage left to 0", 0, 2'b10, 1'b1);

    do_reset();
    @(negedge clk);
    bus.move_req = 4'hF;
    bus.dir = 8'b0101_0101;
    bus.move_allowed = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e.ack = 4'(1 << (k % 4));
      e.gnt = 4'(1 << (k % 4));
      sbq.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rr gap ack", 32'(bus.move_ack), 32'd0);
      check("rr busy", 32'(bus.busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (k == 7) bus.move_req = '0;
      e = sbq.pop_front();
      check("rr ack", 32'(bus.move_ack), 32'(e.ack));
      check("rr granted", 32'(bus.move_granted), 32'(e.gnt));
      my[k % 4] = my[k % 4] + 1;
      check_pos("rr");
    end

    @(negedge clk);
    bus.move_req = 4'b0001;
    bus.dir = 8'b0000_0011;
    bus.move_allowed = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort busy pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    bus.move_req = '0;
    #1;
    model_reset();
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort ack", 32'(bus.move_ack), 32'd0);
    check("abort granted", 32'(bus.move_granted), 32'd0);
    check("abort test_x", 32'(bus.test_x), 32'd0);
    check_pos("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort late ack", 32'(bus.move_ack), 32'd0);
    check_pos("abort after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
